// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the request/ready instruction-memory port and fills IF/ID through a one-entry skid buffer.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched / perf_killed counter outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_inst,
    output logic        ifid_valid,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_killed
`endif
);

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;

    logic        done;
    logic        slot_free;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_plus4;

    assign done         = im_req && im_ready;
    assign slot_free    = !stall || !ifid_valid;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4     = pc_q + 32'd4;

    // im_addr is its own register so it can keep the old address in DRAIN while pc_q already holds the redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REQ;
            pc_q       <= RESET_PC;
            im_req     <= 1'b0;
            im_addr    <= RESET_PC;
            skid_valid <= 1'b0;
            skid_inst  <= NOP_INST;
            skid_pc    <= 32'd0;
            ifid_valid <= 1'b0;
            ifid_inst  <= NOP_INST;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd0;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= NOP_INST;
            skid_valid <= 1'b0;
            pc_q       <= redirect_tgt;
            if (im_req && !im_ready) begin
                state <= DRAIN;
            end else begin
                state   <= REQ;
                im_req  <= 1'b1;
                im_addr <= redirect_tgt;
            end
        end else begin
            case (state)
                REQ: begin
                    if (!im_req) begin
                        im_req  <= 1'b1;
                        im_addr <= pc_q;
                        if (!stall) begin
                            ifid_valid <= 1'b0;
                            ifid_inst  <= NOP_INST;
                        end
                    end else if (im_ready) begin
                        pc_q <= pc_plus4;
                        if (slot_free) begin
                            ifid_valid <= 1'b1;
                            ifid_inst  <= im_inst;
                            ifid_pc    <= pc_q;
                            ifid_pc4   <= pc_plus4;
                            im_addr    <= pc_plus4;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_inst  <= im_inst;
                            skid_pc    <= pc_q;
                            im_req     <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_inst  <= NOP_INST;
                    end
                end
                HOLD: begin
                    // Restart the request in the same edge that drains the skid so no bubble is added.
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_inst  <= skid_inst;
                        ifid_pc    <= skid_pc;
                        ifid_pc4   <= skid_pc + 32'd4;
                        skid_valid <= 1'b0;
                        im_req     <= 1'b1;
                        im_addr    <= pc_q;
                        state      <= REQ;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_inst  <= NOP_INST;
                    end
                    if (im_ready) begin
                        im_addr <= pc_q;
                        state   <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_load;
    logic [31:0] kill_count;

    // A drained response is always a killed word, whether or not another redirect arrives with it.
    always_comb begin
        fetch_load = 1'b0;
        kill_count = 32'd0;
        if (!redirect) begin
            fetch_load = (state == REQ && done && slot_free) || (state == HOLD && !stall);
        end
        if (redirect) begin
            kill_count = 32'(ifid_valid) + 32'(skid_valid);
        end
        if (done && (redirect || state == DRAIN)) begin
            kill_count = kill_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_killed  <= 32'd0;
        end else begin
            perf_fetched <= perf_fetched + 32'(fetch_load);
            perf_killed  <= perf_killed + kill_count;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stall/redirect/latency traffic
// checked against a program-order model of the consumed instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_inst;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    int          assertCount;
    int          failCount;
    int          consumed;
    logic [31:0] expPc;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .im_req(im_req),
        .im_addr(im_addr),
        .im_ready(im_ready),
        .im_inst(im_inst),
        .ifid_valid(ifid_valid),
        .ifid_inst(ifid_inst),
        .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_killed(perf_killed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a per-address unique word so a wrong address or a stale word is visible.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3E1};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic resetDut();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        im_ready    = 1'b1;
        im_inst     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        checkOutput("rst_req", 32'(im_req), 32'd0);
        checkOutput("rst_valid", 32'(ifid_valid), 32'd0);
        checkOutput("rst_inst", ifid_inst, NOP);
        checkOutput("rst_pc", ifid_pc, 32'd0);
        checkOutput("rst_pc4", ifid_pc4, 32'd0);
        reset = 1'b0;
        expPc = RESET_PC;
    endtask

    // One clock of stimulus; the model tracks the PC decode should consume next in program order.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
        logic        pValid;
        logic        pReq;
        logic [31:0] pPc;
        logic [31:0] pAddr;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        im_ready    = rdy;
        im_inst     = rdy ? memWord(im_addr) : 32'hDEAD_BEEF;
        pValid = ifid_valid;
        pReq   = im_req;
        pPc    = ifid_pc;
        pAddr  = im_addr;
        if (r) begin
            expPc = {rpc[31:2], 2'b00};
        end else if (pValid && !s) begin
            checkOutput("consume_pc", pPc, expPc);
            expPc = expPc + 32'd4;
            consumed++;
        end
        @(posedge clk);
        #1;
        if (ifid_valid) begin
            checkOutput("inst_vs_mem", ifid_inst, memWord(ifid_pc));
            checkOutput("pc4", ifid_pc4, ifid_pc + 32'd4);
        end else begin
            checkOutput("nop_inst", ifid_inst, NOP);
        end
        if (r) checkOutput("flush_valid", 32'(ifid_valid), 32'd0);
        if (pReq && !rdy) begin
            checkOutput("req_held", 32'(im_req), 32'd1);
            checkOutput("addr_held", im_addr, pAddr);
        end
        if (pValid && s && !r) begin
            checkOutput("stall_valid", 32'(ifid_valid), 32'd1);
            checkOutput("stall_pc", ifid_pc, pPc);
        end
    endtask

    initial begin
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] killedBefore;
`endif
        assertCount = 0;
        failCount   = 0;
        consumed    = 0;
        expPc       = RESET_PC;

        // Zero-wait streaming: addresses 0..16, IF/ID one cycle behind, first valid on the second edge.
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
            checkOutput("s1_addr", im_addr, 32'(4 * i));
            checkOutput("s1_valid", 32'(ifid_valid), (i >= 1) ? 32'd1 : 32'd0);
            if (i >= 1) checkOutput("s1_pc", ifid_pc, 32'(4 * (i - 1)));
        end

        // Three wait cycles at address 8.
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("s2_addr", im_addr, 32'd8);
            checkOutput("s2_valid", 32'(ifid_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s2_pc", ifid_pc, 32'd8);
        checkOutput("s2_addr_next", im_addr, 32'd12);

        // Stall while the word at 8 returns: it goes to the skid and re-emerges on release.
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
            checkOutput("s3_hold_pc", ifid_pc, 32'd4);
            checkOutput("s3_req", 32'(im_req), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s3_pc", ifid_pc, 32'd8);
        checkOutput("s3_addr", im_addr, 32'd12);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s3_pc_next", ifid_pc, 32'd12);

        // Redirect to 0x43 while the request at 12 is still pending.
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0043, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("s4_addr", im_addr, 32'd12);
            checkOutput("s4_valid", 32'(ifid_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s4_addr_new", im_addr, 32'h40);
        checkOutput("s4_valid_drop", 32'(ifid_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s4_pc", ifid_pc, 32'h40);

        // Redirect together with stall while the skid is full.
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        killedBefore = perf_killed;
`endif
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        checkOutput("s5_valid", 32'(ifid_valid), 32'd0);
        checkOutput("s5_addr", im_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("s5_killed", perf_killed - killedBefore, 32'd2);
`endif
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s5_pc", ifid_pc, 32'h100);

        // Reset in the middle of DRAIN, then fetch restarts at RESET_PC.
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        resetDut();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s6_addr", im_addr, RESET_PC);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s6_pc", ifid_pc, RESET_PC);

        // PC wrap at the top of the address space.
        resetDut();
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        checkOutput("s7_addr", im_addr, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s7_pc_top", ifid_pc, 32'hFFFF_FFFC);
        checkOutput("s7_pc4_wrap", ifid_pc4, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("s7_pc_zero", ifid_pc, 32'd0);

        // Randomized traffic with occasional resets.
        resetDut();
        consumed = 0;
        for (int n = 0; n < 4000; n++) begin
            logic        s;
            logic        r;
            logic        rdy;
            logic [31:0] rpc;
            if ($urandom_range(0, 599) == 0) resetDut();
            s   = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus(s, r, rpc, rdy);
        end
        checkOutput("progress", 32'(consumed >= 400), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
